// File: rtl/matrix_stream_loader.sv
// Streaming front-end for the matrix multiplier. It fills matrix A and then matrix B
// from a valid/ready element stream, and holds both as flat buses until the consumer acks.
module matrix_stream_loader #(
    parameter int M = 2,
    parameter int K = 2,
    parameter int N = 2,
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    input  logic             s_last,
    output logic [M*K*W-1:0] a_flat,
    output logic [K*N*W-1:0] b_flat,
    output logic             mat_valid,
    input  logic             mat_ack,
    output logic             err_len
);

    localparam int AE   = M * K;
    localparam int BE   = K * N;
    localparam int MAXE = (AE > BE) ? AE : BE;
    localparam int IW   = (MAXE > 1) ? $clog2(MAXE) : 1;

    localparam logic [IW-1:0] A_LAST = IW'(AE - 1);
    localparam logic [IW-1:0] B_LAST = IW'(BE - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          xfer;

    // Ready depends only on the registered state, so nothing from s_valid or mat_ack reaches it.
    assign s_ready = (state != HOLD);
    assign xfer    = s_valid && s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD_A;
            idx       <= '0;
            a_flat    <= '0;
            b_flat    <= '0;
            mat_valid <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            err_len <= 1'b0;
            case (state)
                LOAD_A: begin
                    if (xfer) begin
                        a_flat[int'(idx)*W +: W] <= s_data;
                        if (s_last) begin
                            // Early last inside A: drop the frame and restart at A(0,0).
                            err_len <= 1'b1;
                            idx     <= '0;
                        end else if (idx == A_LAST) begin
                            state <= LOAD_B;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
                        b_flat[int'(idx)*W +: W] <= s_data;
                        if (idx == B_LAST) begin
                            idx <= '0;
                            if (s_last) begin
                                state     <= HOLD;
                                mat_valid <= 1'b1;
                            end else begin
                                state   <= LOAD_A;
                                err_len <= 1'b1;
                            end
                        end else if (s_last) begin
                            state   <= LOAD_A;
                            idx     <= '0;
                            err_len <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (mat_ack) begin
                        state     <= LOAD_A;
                        mat_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= LOAD_A;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule
